// File: rtl/execute_issue_pkg.sv
// Shared types for the ID/EX issue stage: operand-1 source select,
// forwarding source and the ALU EXECOP codes.
package execute_issue_pkg;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EX      = 2'd1,
        FWD_MEM     = 2'd2,
        FWD_WB      = 2'd3
    } fwd_src_e;

    typedef enum logic [3:0] {
        EXECOP_ADD  = 4'd0,
        EXECOP_SUB  = 4'd1,
        EXECOP_SLL  = 4'd2,
        EXECOP_SLT  = 4'd3,
        EXECOP_SLTU = 4'd4,
        EXECOP_XOR  = 4'd5,
        EXECOP_SRL  = 4'd6,
        EXECOP_SRA  = 4'd7,
        EXECOP_OR   = 4'd8,
        EXECOP_AND  = 4'd9
    } execop_e;

    // The reserved select value 3 reads rs1, so only PC and ZERO leave it unused.
    function automatic logic uses_rs1(input logic [1:0] sel);
        return !((sel == OP1_PC) || (sel == OP1_ZERO));
    endfunction

endpackage

// File: rtl/execute_issue_operand_forward.sv
// Resolves one source register against the EX, MEM and WB producers and
// flags a stall when the value is still coming from a load.
module execute_issue_operand_forward
    import execute_issue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              used,
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_we,
    input  logic              mem_data_valid,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   data,
    output logic              stall
);

    logic     nonzero;
    logic     ex_hit;
    logic     mem_hit;
    logic     wb_hit;
    fwd_src_e src;

    assign nonzero = |addr;
    assign ex_hit  = nonzero & ex_valid & ex_we & (ex_addr == addr);
    assign mem_hit = nonzero & mem_we & (mem_addr == addr);
    assign wb_hit  = nonzero & wb_we & (wb_addr == addr);

    // A load in EX or an unfinished load in MEM has no value to give yet.
    assign stall = used & ((ex_hit & ex_load) | (mem_hit & !mem_data_valid));

    always_comb begin
        src = FWD_REGFILE;
        if (!stall) begin
            if (ex_hit & !ex_load) begin
                src = FWD_EX;
            end else if (mem_hit) begin
                src = FWD_MEM;
            end else if (wb_hit) begin
                src = FWD_WB;
            end
        end
    end

    always_comb begin
        data = '0;
        case (src)
            FWD_EX:      data = ex_data;
            FWD_MEM:     data = mem_data;
            FWD_WB:      data = wb_data;
            default:     data = nonzero ? rf_data : '0;
        endcase
    end

endmodule

// File: rtl/execute_issue.sv
// ID/EX issue stage: forwards rs1/rs2, selects ALU operands, stalls on
// load-use and registers the instruction for the ALU.
module execute_issue
    import execute_issue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [3:0]        dec_ctrl_i,
    input  logic [XLEN-1:0]   dec_pc_i,
    input  logic [XLEN-1:0]   dec_imm_i,
    input  logic [1:0]        dec_op1_sel_i,
    input  logic              dec_op2_imm_i,
    input  logic [REG_AW-1:0] dec_rs1_addr_i,
    input  logic [REG_AW-1:0] dec_rs2_addr_i,
    input  logic [XLEN-1:0]   dec_rs1_data_i,
    input  logic [XLEN-1:0]   dec_rs2_data_i,
    input  logic [REG_AW-1:0] dec_rd_addr_i,
    input  logic              dec_rd_we_i,
    input  logic              dec_is_load_i,
    input  logic              dec_is_store_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_rd_we_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              mem_data_valid_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              wb_rd_we_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [3:0]        ctrl_o,
    output logic [XLEN-1:0]   operand1_o,
    output logic [XLEN-1:0]   operand2_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              rd_we_o,
    output logic              is_load_o,
    output logic              is_store_o
);

    // Handshakes: decode->stage transfers when dec_valid_i & dec_ready_o,
    // stage->EX transfers when ex_valid_o & ex_ready_i; valid never waits on ready.

    logic            adv;
    logic            hz;
    logic            take;
    logic            use1;
    logic            use2;
    logic            stall1;
    logic            stall2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;

    assign adv  = !ex_valid_o | ex_ready_i;
    assign use1 = uses_rs1(dec_op1_sel_i);
    assign use2 = !dec_op2_imm_i | dec_is_store_i;

    execute_issue_operand_forward #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .used           (use1),
        .addr           (dec_rs1_addr_i),
        .rf_data        (dec_rs1_data_i),
        .ex_valid       (ex_valid_o),
        .ex_we          (rd_we_o),
        .ex_load        (is_load_o),
        .ex_addr        (rd_addr_o),
        .ex_data        (ex_result_i),
        .mem_we         (mem_rd_we_i),
        .mem_data_valid (mem_data_valid_i),
        .mem_addr       (mem_rd_addr_i),
        .mem_data       (mem_data_i),
        .wb_we          (wb_rd_we_i),
        .wb_addr        (wb_rd_addr_i),
        .wb_data        (wb_data_i),
        .data           (rs1_val),
        .stall          (stall1)
    );

    execute_issue_operand_forward #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .used           (use2),
        .addr           (dec_rs2_addr_i),
        .rf_data        (dec_rs2_data_i),
        .ex_valid       (ex_valid_o),
        .ex_we          (rd_we_o),
        .ex_load        (is_load_o),
        .ex_addr        (rd_addr_o),
        .ex_data        (ex_result_i),
        .mem_we         (mem_rd_we_i),
        .mem_data_valid (mem_data_valid_i),
        .mem_addr       (mem_rd_addr_i),
        .mem_data       (mem_data_i),
        .wb_we          (wb_rd_we_i),
        .wb_addr        (wb_rd_addr_i),
        .wb_data        (wb_data_i),
        .data           (rs2_val),
        .stall          (stall2)
    );

    assign hz          = stall1 | stall2;
    assign dec_ready_o = adv & !hz & !flush_i;
    assign take        = dec_valid_i & dec_ready_o;

    always_comb begin
        op1_next = rs1_val;
        case (dec_op1_sel_i)
            OP1_PC:   op1_next = dec_pc_i;
            OP1_ZERO: op1_next = '0;
            default:  op1_next = rs1_val;
        endcase
        op2_next = dec_op2_imm_i ? dec_imm_i : rs2_val;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (take) begin
            ex_valid_o <= 1'b1;
        end else if (adv) begin
            ex_valid_o <= 1'b0;
        end
    end

    // Payload only moves on acceptance; bubbles leave it stale behind ex_valid_o=0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_o       <= EXECOP_ADD;
            operand1_o   <= '0;
            operand2_o   <= '0;
            store_data_o <= '0;
            pc_o         <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            is_load_o    <= 1'b0;
            is_store_o   <= 1'b0;
        end else if (take) begin
            ctrl_o       <= dec_ctrl_i;
            operand1_o   <= op1_next;
            operand2_o   <= op2_next;
            store_data_o <= rs2_val;
            pc_o         <= dec_pc_i;
            rd_addr_o    <= dec_rd_addr_i;
            rd_we_o      <= dec_rd_we_i;
            is_load_o    <= dec_is_load_i;
            is_store_o   <= dec_is_store_i;
        end
    end

endmodule
